// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the burst-master state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HSIZE_WORD    = 2'b10;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

endpackage

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst initiator: turns (addr, len, dir) commands into INCR word beats
// with pipelined address/data phases, wait-state stalls and ERROR abort.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a command; cmd_ready high
// ST_RUN   | address phases still to issue (data phases overlap)
// ST_DRAIN | all addresses accepted; waiting for the last data phase
// ST_ERR   | ERROR response seen (cycle 1); finishing on the HREADY cycle
module ahb_burst_master
    import ahb_pkg::*;
#(
    parameter int LEN_W      = 8,
    parameter int BOUNDARY_W = 10
) (
    input  logic             PORT1HCLK,
    input  logic             HRESETn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_write,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [31:0]      wr_data,
    output logic             rd_valid,
    output logic [31:0]      rd_data,
    output logic             done,
    output logic             err,
    output logic [31:0]      PORT1HADDR,
    output logic [1:0]       PORT1HTRANS,
    output logic             PORT1HWRITE,
    output logic [1:0]       PORT1HSIZE,
    output logic [2:0]       PORT1HBURST,
    output logic [31:0]      PORT1HWDATA,
    input  logic [31:0]      PORT1HRDATA,
    input  logic             PORT1HREADY,
    input  logic [1:0]       PORT1HRESP
);

    localparam int CNT_W = LEN_W + 1;
    typedef logic [CNT_W-1:0] cnt_t;

    state_e      state_q, state_d;
    logic [31:0] haddr_q, haddr_d;
    logic [31:0] nxt_addr_q, nxt_addr_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    cnt_t        addr_left_q, addr_left_d;
    cnt_t        data_left_q, data_left_d;
    logic        rd_valid_q, rd_valid_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // A data phase is outstanding whenever an accepted address has not yet completed.
    logic        data_phase, addr_acc, data_done, err_cycle1;
    logic        wr_gate, issue_ok;
    logic [31:0] issue_addr;
    logic [1:0]  issue_trans;
    cnt_t        cmd_beats, addr_left_nxt;

    // Shared decode used by both the next-state and datapath logic.
    always_comb begin
        data_phase    = (data_left_q != addr_left_q);
        addr_acc      = PORT1HREADY && (htrans_q != HTRANS_IDLE);
        data_done     = PORT1HREADY && data_phase;
        err_cycle1    = data_phase && !PORT1HREADY && (PORT1HRESP != HRESP_OKAY);
        addr_left_nxt = addr_left_q - cnt_t'(addr_acc);
        cmd_beats     = (cmd_len == '0) ? (cnt_t'(1) << LEN_W) : cnt_t'(cmd_len);
        issue_addr    = (state_q == ST_IDLE) ? (cmd_addr & 32'hFFFF_FFFC) : nxt_addr_q;
        wr_gate       = (state_q == ST_IDLE) ? cmd_write : hwrite_q;
        issue_ok      = !wr_gate || wr_valid;
        // Restart with NONSEQ after a gap or when the beat lands on a 1 KB boundary.
        issue_trans   = ((htrans_q == HTRANS_IDLE) || (issue_addr[BOUNDARY_W-1:0] == '0))
                        ? HTRANS_NONSEQ : HTRANS_SEQ;
    end

    // State and bus registers; reset drops any command in flight.
    always_ff @(posedge PORT1HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            haddr_q     <= '0;
            nxt_addr_q  <= '0;
            hwdata_q    <= '0;
            rd_data_q   <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            addr_left_q <= '0;
            data_left_q <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            nxt_addr_q  <= nxt_addr_d;
            hwdata_q    <= hwdata_d;
            rd_data_q   <= rd_data_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            addr_left_q <= addr_left_d;
            data_left_q <= data_left_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_valid) state_d = ST_RUN;
            ST_RUN: begin
                if (err_cycle1)                                  state_d = ST_ERR;
                else if (PORT1HREADY && (addr_left_nxt == '0))   state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (err_cycle1)     state_d = ST_ERR;
                else if (data_done) state_d = ST_IDLE;
            end
            ST_ERR:   if (PORT1HREADY) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: beat issue, counters, write data capture, read return, completion.
    always_comb begin
        haddr_d     = haddr_q;
        nxt_addr_d  = nxt_addr_q;
        hwdata_d    = hwdata_q;
        rd_data_d   = rd_data_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        addr_left_d = addr_left_q;
        data_left_d = data_left_q;
        rd_valid_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_left_d = cmd_beats;
                    data_left_d = cmd_beats;
                    hwrite_d    = cmd_write;
                    nxt_addr_d  = issue_addr;
                    if (issue_ok) begin
                        htrans_d   = HTRANS_NONSEQ;
                        haddr_d    = issue_addr;
                        nxt_addr_d = issue_addr + 32'd4;
                    end
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (err_cycle1) begin
                    // ERROR cycle 1: withdraw any pending address phase immediately.
                    htrans_d = HTRANS_IDLE;
                end else if (PORT1HREADY) begin
                    addr_left_d = addr_left_nxt;
                    if (addr_acc && hwrite_q) hwdata_d = wr_data;
                    if (data_done) begin
                        data_left_d = data_left_q - cnt_t'(1);
                        if (!hwrite_q) begin
                            rd_valid_d = 1'b1;
                            rd_data_d  = PORT1HRDATA;
                        end
                    end
                    if ((state_q == ST_RUN) && (addr_left_nxt != '0) && issue_ok) begin
                        htrans_d   = issue_trans;
                        haddr_d    = issue_addr;
                        nxt_addr_d = issue_addr + 32'd4;
                    end else begin
                        htrans_d = HTRANS_IDLE;
                    end
                    if ((state_q == ST_DRAIN) && data_done) done_d = 1'b1;
                end
            end
            ST_ERR: begin
                htrans_d = HTRANS_IDLE;
                if (PORT1HREADY) begin
                    addr_left_d = '0;
                    data_left_d = '0;
                    done_d      = 1'b1;
                    err_d       = 1'b1;
                end
            end
            default: htrans_d = HTRANS_IDLE;
        endcase
    end

    // Outputs: handshakes decoded from state, bus signals straight from flops.
    always_comb begin
        cmd_ready   = (state_q == ST_IDLE);
        wr_ready    = (state_q == ST_RUN) && addr_acc && hwrite_q;
        rd_valid    = rd_valid_q;
        rd_data     = rd_data_q;
        done        = done_q;
        err         = err_q;
        PORT1HADDR  = haddr_q;
        PORT1HTRANS = htrans_q;
        PORT1HWRITE = hwrite_q;
        PORT1HSIZE  = HSIZE_WORD;
        PORT1HBURST = HBURST_INCR;
        PORT1HWDATA = hwdata_q;
    end

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: the bench plays the AHB slave and the
// local producer/consumer, with hand-computed expected bus activity per cycle.
module tb_ahb_burst_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, done, err;
    logic [31:0] rd_data;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans, hsize, hresp;
    logic        hwrite, hready;
    logic [2:0]  hburst;

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;
    int n;

    always #5 clk = ~clk;

    ahb_burst_master #(.LEN_W(8), .BOUNDARY_W(10)) dut (
        .PORT1HCLK   (clk),
        .HRESETn     (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_write   (cmd_write),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .done        (done),
        .err         (err),
        .PORT1HADDR  (haddr),
        .PORT1HTRANS (htrans),
        .PORT1HWRITE (hwrite),
        .PORT1HSIZE  (hsize),
        .PORT1HBURST (hburst),
        .PORT1HWDATA (hwdata),
        .PORT1HRDATA (hrdata),
        .PORT1HREADY (hready),
        .PORT1HRESP  (hresp)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rd_valid === 1'b1) rd_cnt++;
    endtask

    task automatic cmd(input logic [31:0] a, input logic [7:0] l, input logic w);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_write = w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_write = 1'b0;
        wr_valid = 1'b0; wr_data = '0; hrdata = '0; hready = 1'b1; hresp = 2'b00;
        #12;
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst htrans",    htrans, 0);
        chk("rst haddr",     haddr, 0);
        chk("rst hwrite",    hwrite, 0);
        chk("rst hsize",     hsize, 2);
        chk("rst hburst",    hburst, 1);
        chk("rst hwdata",    hwdata, 0);
        chk("rst wr_ready",  wr_ready, 0);
        chk("rst rd_valid",  rd_valid, 0);
        chk("rst rd_data",   rd_data, 0);
        chk("rst done",      done, 0);
        chk("rst err",       err, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        tick(); tick();

        // 4-word write, zero wait; low address bits must be ignored
        cmd(32'h0000_0101, 8'd4, 1'b1); wr_valid = 1'b1; wr_data = 32'hD000_0000;
        tick(); cmd_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            wr_data = 32'hD000_0000 + b;
            #1;
            chk("w4 htrans", htrans, (b == 0) ? 32'd2 : 32'd3);
            chk("w4 haddr", haddr, 32'h100 + 4 * b);
            chk("w4 wr_ready", wr_ready, 1);
            if (b > 0) chk("w4 hwdata", hwdata, 32'hD000_0000 + b - 1);
            chk("w4 done early", done, 0);
            tick();
        end
        wr_valid = 1'b0;
        chk("w4 drain htrans", htrans, 0);
        chk("w4 drain hwdata", hwdata, 32'hD000_0003);
        chk("w4 drain done", done, 0);
        tick();
        chk("w4 done", done, 1);
        chk("w4 err", err, 0);
        chk("w4 cmd_ready", cmd_ready, 1);
        tick();
        chk("w4 done pulse", done, 0);

        // 3-word read crossing the 1 KB boundary
        rd_cnt = 0;
        cmd(32'h0000_03F8, 8'd3, 1'b0);
        tick(); cmd_valid = 1'b0;
        chk("r3 htrans0", htrans, 2); chk("r3 haddr0", haddr, 32'h3F8); chk("r3 hwrite", hwrite, 0);
        chk("r3 wr_ready", wr_ready, 0);
        tick(); hrdata = 32'hA000_0000;
        chk("r3 htrans1", htrans, 3); chk("r3 haddr1", haddr, 32'h3FC);
        tick(); hrdata = 32'hA000_0001;
        chk("r3 rd_valid0", rd_valid, 1); chk("r3 rd_data0", rd_data, 32'hA000_0000);
        chk("r3 htrans2", htrans, 2); chk("r3 haddr2", haddr, 32'h400);
        tick(); hrdata = 32'hA000_0002;
        chk("r3 rd_data1", rd_data, 32'hA000_0001); chk("r3 htrans idle", htrans, 0);
        tick();
        chk("r3 rd_data2", rd_data, 32'hA000_0002); chk("r3 done", done, 1); chk("r3 err", err, 0);
        tick();
        chk("r3 rd_valid off", rd_valid, 0);
        chk("r3 rd_cnt", rd_cnt, 3);

        // 4-word write with 2 wait states on beat 1's data phase
        cmd(32'h0000_0200, 8'd4, 1'b1); wr_valid = 1'b1; wr_data = 32'hB0;
        tick(); cmd_valid = 1'b0;
        chk("ws htrans0", htrans, 2); chk("ws haddr0", haddr, 32'h200);
        tick(); wr_data = 32'hB1;
        chk("ws htrans1", htrans, 3); chk("ws haddr1", haddr, 32'h204); chk("ws hwdata0", hwdata, 32'hB0);
        tick(); wr_data = 32'hB2; hready = 1'b0;
        chk("ws a haddr", haddr, 32'h208); chk("ws a hwdata", hwdata, 32'hB1);
        #1; chk("ws a wr_ready", wr_ready, 0);
        tick();
        chk("ws b htrans", htrans, 3); chk("ws b haddr", haddr, 32'h208); chk("ws b hwdata", hwdata, 32'hB1);
        tick(); hready = 1'b1;
        chk("ws c htrans", htrans, 3); chk("ws c haddr", haddr, 32'h208); chk("ws c hwdata", hwdata, 32'hB1);
        tick(); wr_data = 32'hB3;
        chk("ws haddr3", haddr, 32'h20C); chk("ws hwdata2", hwdata, 32'hB2);
        tick(); wr_valid = 1'b0;
        chk("ws idle", htrans, 0); chk("ws hwdata3", hwdata, 32'hB3); chk("ws not done", done, 0);
        tick();
        chk("ws done", done, 1); chk("ws err", err, 0);
        tick();

        // write with wr_valid low for 3 cycles mid-burst
        cmd(32'h0000_0300, 8'd4, 1'b1); wr_valid = 1'b1; wr_data = 32'hC0;
        tick(); cmd_valid = 1'b0;
        chk("gap htrans0", htrans, 2); chk("gap haddr0", haddr, 32'h300);
        tick(); wr_data = 32'hC1; wr_valid = 1'b0;
        chk("gap htrans1", htrans, 3); chk("gap haddr1", haddr, 32'h304);
        tick();
        chk("gap idle1", htrans, 0); chk("gap hwdata1", hwdata, 32'hC1);
        #1; chk("gap wr_ready", wr_ready, 0);
        tick();
        chk("gap idle2", htrans, 0);
        tick(); wr_valid = 1'b1; wr_data = 32'hC2;
        chk("gap idle3", htrans, 0);
        tick();
        chk("gap resume nonseq", htrans, 2); chk("gap resume haddr", haddr, 32'h308);
        tick(); wr_data = 32'hC3;
        chk("gap htrans3", htrans, 3); chk("gap haddr3", haddr, 32'h30C); chk("gap hwdata2", hwdata, 32'hC2);
        tick(); wr_valid = 1'b0;
        chk("gap drain", htrans, 0); chk("gap hwdata3", hwdata, 32'hC3);
        tick();
        chk("gap done", done, 1);
        tick();

        // ERROR on beat 2 of an 8-word read
        rd_cnt = 0;
        cmd(32'h0000_0500, 8'd8, 1'b0);
        tick(); cmd_valid = 1'b0;
        chk("er haddr0", haddr, 32'h500);
        tick(); hrdata = 32'hE0;
        chk("er haddr1", haddr, 32'h504);
        tick(); hrdata = 32'hE1;
        chk("er rd_data0", rd_data, 32'hE0); chk("er haddr2", haddr, 32'h508);
        tick(); hrdata = 32'hE2; hready = 1'b0; hresp = 2'b01;
        chk("er rd_data1", rd_data, 32'hE1); chk("er htrans pre", htrans, 3);
        tick(); hready = 1'b1;
        chk("er cycle2 htrans", htrans, 0); chk("er cycle2 rd_valid", rd_valid, 0);
        chk("er cycle2 done", done, 0);
        tick(); hresp = 2'b00;
        chk("er done", done, 1); chk("er err", err, 1); chk("er htrans", htrans, 0);
        chk("er rd_valid", rd_valid, 0); chk("er cmd_ready", cmd_ready, 1);
        tick();
        chk("er done pulse", done, 0); chk("er err pulse", err, 0); chk("er htrans after", htrans, 0);
        chk("er rd_cnt", rd_cnt, 2);

        // cmd_len=0 -> 256 beats
        rd_cnt = 0; hrdata = 32'h5A5A_0000;
        cmd(32'h0000_0000, 8'd0, 1'b0);
        tick(); cmd_valid = 1'b0;
        chk("l256 htrans0", htrans, 2); chk("l256 haddr0", haddr, 0);
        n = 1;
        while (done !== 1'b1 && n < 300) begin
            if (n == 256) begin
                chk("l256 last haddr", haddr, 32'h3FC);
                chk("l256 last htrans", htrans, 3);
            end
            tick();
            n++;
        end
        chk("l256 done cycle", n, 258);
        chk("l256 rd_cnt", rd_cnt, 256);
        tick();

        // asynchronous reset mid-burst, then a normal single-word read
        cmd(32'h0000_0600, 8'd4, 1'b1); wr_valid = 1'b1; wr_data = 32'h66;
        tick(); cmd_valid = 1'b0;
        tick();
        chk("rm pre htrans", htrans, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("rm htrans", htrans, 0); chk("rm haddr", haddr, 0); chk("rm hwdata", hwdata, 0);
        chk("rm hwrite", hwrite, 0); chk("rm cmd_ready", cmd_ready, 1); chk("rm wr_ready", wr_ready, 0);
        @(posedge clk); #1; rst_n = 1'b1; wr_valid = 1'b0;
        tick();
        chk("rm no done", done, 0);
        cmd(32'h0000_0704, 8'd1, 1'b0);
        tick(); cmd_valid = 1'b0;
        chk("rm r1 htrans", htrans, 2); chk("rm r1 haddr", haddr, 32'h704);
        tick(); hrdata = 32'hF1;
        chk("rm r1 idle", htrans, 0);
        tick();
        chk("rm r1 rd_valid", rd_valid, 1); chk("rm r1 rd_data", rd_data, 32'hF1);
        chk("rm r1 done", done, 1); chk("rm r1 err", err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
